pc_loop_stack: RTL
==================

Name: pc_loop_stack

Overview:
Parametrised program-counter register with a hardware loop-base stack. It generalises the single-base PC register to WIDTH-bit addresses and DEPTH nested loop bases. The control unit uses it to jump, increment, and branch back to the innermost loop start. It sits between the bus (BusOut) and instruction-memory address logic, with overflow/underflow error reporting to the control FSM.

Parameters:
WIDTH, 8, address/counter width in bits (>=2)
DEPTH, 4, number of loop-base stack entries (>=1)
RESET_ADDR, 0, value of dout after RST; value of top when stack empty

Ports:
Clk  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
Wen  input  1  load dout from BusOut (jump)
BusOut  input  WIDTH  jump target / loop base value
PUSH  input  1  with Wen: also push BusOut onto loop stack; ignored when Wen=0
POP  input  1  discard top-of-stack entry (loop exit)
LOOP  input  1  dout <= top-of-stack (branch to loop start)
INC  input  1  dout <= dout + 1
dout  output  WIDTH  current PC value (registered)
top  output  WIDTH  current top-of-stack, RESET_ADDR when empty (registered)
level  output  clog2(DEPTH+1)  number of valid stack entries
full  output  1  level == DEPTH
empty  output  1  level == 0
err  output  1  sticky stack-misuse flag

Behaviour:
- Reset: RST=1 at rising edge -> dout=RESET_ADDR, level=0, empty=1, full=0, top=RESET_ADDR, err=0; all other inputs ignored that cycle. RST mid-loop discards every stack entry. Initial (power-up) values are identical to reset values.
- dout update priority per cycle: Wen > LOOP > INC > hold.
  - Wen: dout <= BusOut.
  - LOOP (Wen=0): if !empty, dout <= top (pre-pop value); if empty, dout holds and err <= 1.
  - INC (Wen=0, LOOP=0): dout <= dout + 1 mod 2^WIDTH; all-ones wraps to 0, no flag.
- Stack ops are evaluated independently of the dout priority.
  - Effective push = Wen & PUSH.
  - Push only: if !full, entry[level] <= BusOut and level+1; if full, push ignored, stack unchanged, err <= 1.
  - Pop only: if !empty, level-1; if empty, ignored and err <= 1.
  - Push and pop together: if !empty, top entry replaced by BusOut and level unchanged (no error even when full). If empty, treated as a plain push: level becomes 1, no error.
  - LOOP+POP together: dout takes the pre-pop top, then the entry is popped ("last iteration branch"). If empty, err <= 1 once and nothing changes.
- Latency: all effects are visible on outputs the cycle after the sampling edge. top/full/empty/level are consistent with each other every cycle.
- err is sticky and cleared only by RST. A misuse never corrupts dout or stack contents beyond the rules above.
- Arithmetic: level is an unsigned counter and never exceeds DEPTH or drops below 0. Stack entries are not cleared on pop; they are simply no longer valid.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset/increment, WIDTH=8: RST, then INC held 257 cycles -> dout counts 0,1,..,255,0,1. err=0, empty=1, top=0.
2. Nested loops: Wen+PUSH BusOut=0x10, INC x3 (dout=0x13), Wen+PUSH 0x20 (level=2, top=0x20), INC x2, LOOP -> dout=0x20. LOOP+POP -> dout=0x20, level=1, top=0x10. LOOP -> dout=0x10.
3. Overflow, DEPTH=4: five Wen+PUSH with 0x01..0x05 -> after 4th full=1, top=0x04. 5th push leaves level=4, top=0x04, err=1, dout=0x05.
4. Underflow: after RST, POP -> level=0, err=1. After RST, LOOP with dout=0x33 (set via Wen) -> dout stays 0x33, err=1.
5. Simultaneous events: with level=4, Wen+PUSH+POP BusOut=0x7E -> level=4, top=0x7E, err=0. Wen+LOOP+INC BusOut=0x40 -> dout=0x40 (Wen wins), stack unchanged.
6. Reset mid-operation: level=3, err=1, dout=0x9A; assert RST together with Wen+PUSH BusOut=0x55 -> next cycle dout=0, level=0, empty=1, err=0, top=0.

Source files
------------

// File: rtl/pc_loop_stack.sv
// Program counter with a DEPTH-entry hardware loop-base stack.
// The PC can jump, increment, or branch back to the innermost loop base; stack misuse raises a sticky error.
module pc_loop_stack #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = {WIDTH{1'b0}}
) (
  input  logic                       Clk,
  input  logic                       RST,
  input  logic                       Wen,
  input  logic [WIDTH-1:0]           BusOut,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic                       LOOP,
  input  logic                       INC,
  output logic [WIDTH-1:0]           dout,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] dout_q  = RESET_ADDR;
  logic [WIDTH-1:0] top_q   = RESET_ADDR;
  logic [LW-1:0]    level_q = {LW{1'b0}};
  logic             full_q  = 1'b0;
  logic             empty_q = 1'b1;
  logic             err_q   = 1'b0;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] top_d;
  logic [LW-1:0]    level_d;
  logic             err_d;
  logic             push_s;
  logic             we_s;
  logic [LW-1:0]    wr_idx_s;
  logic [WIDTH-1:0] below_s;

  assign push_s = Wen & PUSH;

  // Entry just beneath the current top; becomes the new top after a pop.
  always_comb begin
    below_s = RESET_ADDR;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (int'(level_q) == i + 2) begin
        below_s = stack_q[i];
      end else begin
        below_s = below_s;
      end
    end
  end

  // Next-state: PC priority chain and stack operations evaluated side by side.
  always_comb begin
    dout_d   = dout_q;
    top_d    = top_q;
    level_d  = level_q;
    err_d    = err_q;
    we_s     = 1'b0;
    wr_idx_s = {LW{1'b0}};

    if (Wen) begin
      dout_d = BusOut;
    end else if (LOOP) begin
      if (!empty_q) begin
        dout_d = top_q;
      end else begin
        err_d = 1'b1;
      end
    end else if (INC) begin
      dout_d = dout_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      dout_d = dout_q;
    end

    case ({push_s, POP})
      2'b11: begin
        // Replace-top; on an empty stack this degenerates to a plain push.
        we_s  = 1'b1;
        top_d = BusOut;
        if (!empty_q) begin
          wr_idx_s = level_q - LW'(1'b1);
        end else begin
          wr_idx_s = {LW{1'b0}};
          level_d  = LW'(1'b1);
        end
      end
      2'b10: begin
        if (!full_q) begin
          we_s     = 1'b1;
          wr_idx_s = level_q;
          level_d  = level_q + LW'(1'b1);
          top_d    = BusOut;
        end else begin
          err_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_q) begin
          level_d = level_q - LW'(1'b1);
          top_d   = below_s;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        level_d = level_q;
      end
    endcase
  end

  // PC, level, cached top and flags.
  always_ff @(posedge Clk) begin
    if (RST) begin
      dout_q  <= RESET_ADDR;
      top_q   <= RESET_ADDR;
      level_q <= {LW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      top_q   <= top_d;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == {LW{1'b0}});
      err_q   <= err_d;
    end
  end

  // Stack storage; entries are never cleared, only invalidated by level.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!RST && we_s && int'(wr_idx_s) == i) begin
        stack_q[i] <= BusOut;
      end else begin
        stack_q[i] <= stack_q[i];
      end
    end
  end

  assign dout  = dout_q;
  assign top   = top_q;
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule
